// File: rtl/axi_uart_fifo.sv
`timescale 1ns/1ps
// Buffered AXI4-Stream UART: TX and RX FIFOs around a serial shifter pair with
// runtime parity (none/even/odd), one or two stop bits and per-frame error pulses.
module axi_uart_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  input  logic                           rxd,
  output logic                           txd,
  output logic                           tx_busy,
  output logic                           rx_busy,
  output logic [$clog2(TX_FIFO_DEPTH):0] tx_fifo_count,
  output logic [$clog2(RX_FIFO_DEPTH):0] rx_fifo_count,
  output logic                           rx_overrun_error,
  output logic                           rx_frame_error,
  output logic                           rx_parity_error,
  input  logic [15:0]                    prescale,
  input  logic [1:0]                     parity_mode,
  input  logic                           stop_bits
);

  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [TX_AW:0] TX_FULL  = (TX_AW+1)'(TX_FIFO_DEPTH);
  localparam logic [RX_AW:0] RX_FULL  = (RX_AW+1)'(RX_FIFO_DEPTH);
  localparam logic [3:0]     LAST_IDX = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  // Configuration decode; every frame latches these at its start.
  logic [15:0] ps_eff;
  logic [18:0] period_cfg;
  logic [18:0] half_cfg;
  logic        par_en_cfg;
  logic        par_odd_cfg;

  assign ps_eff      = (prescale == 16'd0) ? 16'd1 : prescale;
  assign period_cfg  = {ps_eff, 3'b000};
  assign half_cfg    = {1'b0, ps_eff, 2'b00};
  assign par_en_cfg  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign par_odd_cfg = (parity_mode == 2'b10);

  // Stream handshake: a word moves on a rising edge where valid && ready are both
  // high; valid never depends on ready, and s_axis_tready drops only when full.

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [TX_FIFO_DEPTH];
  logic [TX_AW-1:0]      tx_wr_ptr;
  logic [TX_AW-1:0]      tx_rd_ptr;
  logic [TX_AW:0]        tx_count_q;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_fifo_ne;

  assign s_axis_tready = (tx_count_q != TX_FULL);
  assign tx_push       = s_axis_tvalid && s_axis_tready;
  assign tx_fifo_ne    = (tx_count_q != '0);
  assign tx_fifo_count = tx_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + 1'b1;
      else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= s_axis_tdata;
  end

  // ---------------- TX FSM ----------------
  uart_state_e           tx_state_q;
  uart_state_e           tx_state_d;
  logic [18:0]           tx_cnt;
  logic [18:0]           tx_period;
  logic [3:0]            tx_idx;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par_en;
  logic                  tx_par_bit;
  logic                  tx_stop2_pending;
  logic                  tx_tick;

  assign tx_tick = (tx_cnt == 19'd0);
  assign tx_busy = (tx_state_q != S_IDLE) || tx_fifo_ne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_q <= S_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_fifo_ne) begin
          tx_pop     = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START:  if (tx_tick) tx_state_d = S_DATA;
      S_DATA:   if (tx_tick && (tx_idx == LAST_IDX)) tx_state_d = tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_state_d = S_STOP;
      S_STOP: begin
        // Chain straight into the next start bit so streamed frames have no gap.
        if (tx_tick && !tx_stop2_pending) begin
          if (tx_fifo_ne) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd              <= 1'b1;
      tx_cnt           <= '0;
      tx_period        <= '0;
      tx_idx           <= '0;
      tx_shift         <= '0;
      tx_par_en        <= 1'b0;
      tx_par_bit       <= 1'b0;
      tx_stop2_pending <= 1'b0;
    end else if (tx_pop) begin
      tx_shift         <= tx_mem[tx_rd_ptr];
      tx_par_bit       <= (^tx_mem[tx_rd_ptr]) ^ par_odd_cfg;
      tx_par_en        <= par_en_cfg;
      tx_stop2_pending <= stop_bits;
      tx_period        <= period_cfg;
      tx_cnt           <= period_cfg - 19'd1;
      tx_idx           <= '0;
      txd              <= 1'b0;
    end else if (tx_state_q != S_IDLE) begin
      if (!tx_tick) begin
        tx_cnt <= tx_cnt - 19'd1;
      end else begin
        tx_cnt <= tx_period - 19'd1;
        case (tx_state_q)
          S_START: txd <= tx_shift[0];
          S_DATA: begin
            if (tx_idx == LAST_IDX) begin
              txd <= tx_par_en ? tx_par_bit : 1'b1;
            end else begin
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
              tx_idx   <= tx_idx + 4'd1;
            end
          end
          S_PARITY: txd <= 1'b1;
          S_STOP: begin
            tx_stop2_pending <= 1'b0;
            txd              <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- RX synchroniser ----------------
  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_prev;
  logic       rx_fall;

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_e           rx_state_q;
  uart_state_e           rx_state_d;
  logic [18:0]           rx_cnt;
  logic [18:0]           rx_period;
  logic [3:0]            rx_idx;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_par_en;
  logic                  rx_par_odd;
  logic                  rx_par_bit;
  logic                  rx_tick;
  logic                  rx_done;
  logic                  rx_stop_bad;
  logic                  rx_par_bad;
  logic                  rx_full;
  logic                  rx_pop;
  logic                  rx_push;

  assign rx_tick = (rx_cnt == 19'd0);
  assign rx_busy = (rx_state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_q <= S_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE:   if (rx_fall) rx_state_d = S_START;
      S_START:  if (rx_tick) rx_state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && (rx_idx == LAST_IDX)) rx_state_d = rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_state_d = S_STOP;
      S_STOP: begin
        // Only the first stop bit is examined; idling through the rest lets a
        // following start edge be caught during a second stop bit.
        if (rx_tick) begin
          rx_done    = 1'b1;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_period  <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
    end else if (rx_state_q == S_IDLE) begin
      if (rx_fall) begin
        rx_cnt     <= half_cfg - 19'd1;
        rx_period  <= period_cfg;
        rx_par_en  <= par_en_cfg;
        rx_par_odd <= par_odd_cfg;
        rx_idx     <= '0;
      end
    end else if (!rx_tick) begin
      rx_cnt <= rx_cnt - 19'd1;
    end else begin
      rx_cnt <= rx_period - 19'd1;
      case (rx_state_q)
        S_DATA: begin
          rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
          rx_idx   <= rx_idx + 4'd1;
        end
        S_PARITY: rx_par_bit <= rx_s;
        default: ;
      endcase
    end
  end

  // Frame outcome, highest priority first: bad stop, bad parity, overrun.
  assign rx_stop_bad = !rx_s;
  assign rx_par_bad  = rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_par_odd));
  assign rx_push     = rx_done && !rx_stop_bad && !rx_par_bad && (!rx_full || rx_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_frame_error   <= 1'b0;
      rx_parity_error  <= 1'b0;
      rx_overrun_error <= 1'b0;
    end else begin
      rx_frame_error   <= rx_done && rx_stop_bad;
      rx_parity_error  <= rx_done && !rx_stop_bad && rx_par_bad;
      rx_overrun_error <= rx_done && !rx_stop_bad && !rx_par_bad && rx_full && !rx_pop;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [RX_AW-1:0]      rx_wr_ptr;
  logic [RX_AW-1:0]      rx_rd_ptr;
  logic [RX_AW:0]        rx_count_q;

  assign rx_full       = (rx_count_q == RX_FULL);
  assign m_axis_tvalid = (rx_count_q != '0);
  assign m_axis_tdata  = rx_mem[rx_rd_ptr];
  assign rx_pop        = m_axis_tvalid && m_axis_tready;
  assign rx_fifo_count = rx_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count_q <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
      else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

endmodule

// File: tb/tb_axi_uart_fifo.sv
`timescale 1ns/1ps
// Bench for axi_uart_fifo: directed TX, loopback, overrun, error, full-FIFO and
// reset scenarios; received bytes are scored against an expected queue.
module tb_axi_uart_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          rxd_line;
  logic          rxd_drv;
  logic          loop_en;
  logic          txd;
  logic          tx_busy;
  logic          rx_busy;
  logic [4:0]    tx_fifo_count;
  logic [4:0]    rx_fifo_count;
  logic          rx_overrun_error;
  logic          rx_frame_error;
  logic          rx_parity_error;
  logic [15:0]   prescale;
  logic [1:0]    parity_mode;
  logic          stop_bits;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr    = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  logic [DW-1:0] exp_q[$];

  assign rxd_line = loop_en ? txd : rxd_drv;

  axi_uart_fifo #(
    .DATA_WIDTH(DW), .TX_FIFO_DEPTH(DEPTH), .RX_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rxd(rxd_line), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .tx_fifo_count(tx_fifo_count), .rx_fifo_count(rx_fifo_count),
    .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
    .rx_parity_error(rx_parity_error),
    .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, required to finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: scores every RX byte the DUT hands over, and counts error pulses.
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got %02h, required no output", m_axis_tdata);
      end else begin
        check("rx_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
      end
    end
    if (rx_overrun_error) n_ovr++;
    if (rx_frame_error)   n_ferr++;
    if (rx_parity_error)  n_perr++;
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [DW-1:0] d);
    int guard;
    guard         = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: tready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    rxd_drv = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pm,
                            input bit flip_par, input bit bad_stop, input int ps);
    int   bp;
    logic p;
    bp = ps * 8;
    p  = (^d) ^ (pm == 2'b10) ^ flip_par;
    drive_bit(1'b0, bp);
    for (int i = 0; i < DW; i++) drive_bit(d[i], bp);
    if (pm == 2'b01 || pm == 2'b10) drive_bit(p, bp);
    drive_bit(~bad_stop, bp);
    drive_bit(1'b1, bp);
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_busy || tx_busy || m_axis_tvalid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] t1_bits;
  int ovr0, ferr0, perr0, n;
  logic [DW-1:0] t2_vec [4];

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    rxd_drv       = 1'b1;
    loop_en       = 1'b0;
    prescale      = 16'd1;
    parity_mode   = 2'b00;
    stop_bits     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_busy", 32'({tx_busy, rx_busy}), 32'd0);
    check("rst_counts", 32'({tx_fifo_count, rx_fifo_count}), 32'd0);
    check("rst_errors", 32'({rx_overrun_error, rx_frame_error, rx_parity_error}), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: start-bit latency and exact bit pattern of 0xA5
    t1_bits = 10'b1101001010;
    push_byte(8'hA5);
    @(negedge clk);
    check("t1_idle_before_start", 32'(txd), 32'd1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (c == 0 || c == 7) check($sformatf("t1_bit%0d_c%0d", b, c), 32'(txd), 32'(t1_bits[b]));
      end
    end
    @(negedge clk);
    check("t1_idle_after", 32'(txd), 32'd1);
    check("t1_tx_busy_after", 32'(tx_busy), 32'd0);

    // T2: loopback, even parity, two stop bits
    @(posedge clk);
    #1;
    loop_en     = 1'b1;
    prescale    = 16'd2;
    parity_mode = 2'b01;
    stop_bits   = 1'b1;
    ovr0 = n_ovr; ferr0 = n_ferr; perr0 = n_perr;
    t2_vec = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(t2_vec[i]);
      push_byte(t2_vec[i]);
    end
    wait_drain(3000, "t2_drain");
    check("t2_no_ovr", 32'(n_ovr - ovr0), 32'd0);
    check("t2_no_ferr", 32'(n_ferr - ferr0), 32'd0);
    check("t2_no_perr", 32'(n_perr - perr0), 32'd0);

    // T3: RX overrun with the consumer stalled
    loop_en       = 1'b0;
    prescale      = 16'd1;
    parity_mode   = 2'b00;
    stop_bits     = 1'b0;
    m_axis_tready = 1'b0;
    ovr0 = n_ovr; ferr0 = n_ferr; perr0 = n_perr;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(8'h30 + i));
      send_frame(8'(8'h30 + i), 2'b00, 1'b0, 1'b0, 1);
    end
    @(negedge clk);
    check("t3_rx_count_full", 32'(rx_fifo_count), 32'd16);
    check("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t3_head", 32'(m_axis_tdata), 32'h30);
    check("t3_one_ovr", 32'(n_ovr - ovr0), 32'd1);
    check("t3_no_ferr", 32'(n_ferr - ferr0), 32'd0);
    check("t3_no_perr", 32'(n_perr - perr0), 32'd0);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain(200, "t3_drain");
    check("t3_rx_count_empty", 32'(rx_fifo_count), 32'd0);

    // T4: parity error, frame error, both (frame wins), glitch, then a good frame
    parity_mode = 2'b10;
    ovr0 = n_ovr; ferr0 = n_ferr; perr0 = n_perr;
    send_frame(8'h3C, 2'b10, 1'b1, 1'b0, 1);
    check("t4_perr_pulse", 32'(n_perr - perr0), 32'd1);
    check("t4_perr_no_ferr", 32'(n_ferr - ferr0), 32'd0);
    check("t4_perr_count", 32'(rx_fifo_count), 32'd0);
    send_frame(8'h55, 2'b10, 1'b0, 1'b1, 1);
    check("t4_ferr_pulse", 32'(n_ferr - ferr0), 32'd1);
    check("t4_ferr_no_perr", 32'(n_perr - perr0), 32'd1);
    send_frame(8'hA6, 2'b10, 1'b1, 1'b1, 1);
    check("t4_both_ferr", 32'(n_ferr - ferr0), 32'd2);
    check("t4_both_no_perr", 32'(n_perr - perr0), 32'd1);
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 40);
    check("t4_glitch_idle", 32'(rx_busy), 32'd0);
    check("t4_glitch_flags", 32'((n_ferr - ferr0) + (n_perr - perr0)), 32'd3);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 2'b10, 1'b0, 1'b0, 1);
    wait_drain(200, "t4_drain");
    check("t4_no_ovr", 32'(n_ovr - ovr0), 32'd0);

    // T5: TX FIFO full at prescale 100, looped back to confirm order
    loop_en     = 1'b1;
    prescale    = 16'd100;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      exp_q.push_back(8'(8'hC0 + i));
      push_byte(8'(8'hC0 + i));
    end
    @(negedge clk);
    check("t5_tx_count_full", 32'(tx_fifo_count), 32'd16);
    check("t5_tready_low", 32'(s_axis_tready), 32'd0);
    prescale = 16'd1;
    n = 0;
    while (!s_axis_tready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("t5_tready_returns", 32'(s_axis_tready), 32'd1);
    check("t5_tx_count_after_pop", 32'(tx_fifo_count), 32'd15);
    wait_drain(5000, "t5_drain");

    // T6: reset during TX and RX DATA
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    repeat (120) @(posedge clk);
    #1;
    check("t6_pre_rx_busy", 32'(rx_busy), 32'd1);
    check("t6_pre_counts", 32'({tx_fifo_count, rx_fifo_count}), 32'({5'd1, 5'd1}));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_txd", 32'(txd), 32'd1);
    check("t6_rst_counts", 32'({tx_fifo_count, rx_fifo_count}), 32'd0);
    check("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_busy", 32'({tx_busy, rx_busy}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    exp_q.push_back(8'h3C);
    push_byte(8'h3C);
    wait_drain(500, "t6_drain");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
